// File: rtl/synaptic_accumulator_seq.sv
// Time-multiplexed synaptic integrator: one sequential adder accumulates N_SYN
// spike-gated weights per neuron and emits one signed sum per neuron over valid/ready.
//
// state | meaning
// IDLE  | waiting for start; no handshakes offered
// ACC   | accepting weight beats, accumulating the current neuron
// EMIT  | holding the registered sum until downstream accepts it
module synaptic_accumulator_seq #(
  parameter int N_NEURON  = 8,
  parameter int N_SYN     = 16,
  parameter int WIDTH     = 16,
  parameter int OUT_WIDTH = 24,
  parameter int SATURATE  = 1,
  localparam int IDX_W    = (N_NEURON > 1) ? $clog2(N_NEURON) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_weight,
  input  logic                 in_spike,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_sum,
  output logic [IDX_W-1:0]     out_idx,
  output logic                 out_sat
);

  localparam int SYN_W = $clog2(N_SYN);
  localparam logic [SYN_W-1:0]     SYN_LAST = SYN_W'(N_SYN - 1);
  localparam logic [IDX_W-1:0]     NRN_LAST = IDX_W'(N_NEURON - 1);
  localparam logic [OUT_WIDTH-1:0] SUM_MAX  = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] SUM_MIN  = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t               state;
  logic [OUT_WIDTH-1:0] acc;
  logic                 sat_flag;
  logic [SYN_W-1:0]     syn_cnt;
  logic [IDX_W-1:0]     nrn_cnt;

  logic [OUT_WIDTH:0]   w_ext;
  logic [OUT_WIDTH:0]   a_ext;
  logic [OUT_WIDTH:0]   sum_ext;
  logic                 ovf;
  logic [OUT_WIDTH-1:0] acc_nxt;
  logic                 sat_nxt;

  // One extra bit of headroom: the two top bits disagree exactly on overflow.
  always_comb begin
    w_ext   = {{(OUT_WIDTH+1-WIDTH){in_weight[WIDTH-1]}}, in_weight};
    a_ext   = {acc[OUT_WIDTH-1], acc};
    sum_ext = a_ext + w_ext;
    ovf     = sum_ext[OUT_WIDTH] ^ sum_ext[OUT_WIDTH-1];
    acc_nxt = acc;
    sat_nxt = sat_flag;
    if (in_spike) begin
      acc_nxt = sum_ext[OUT_WIDTH-1:0];
      if (ovf) begin
        sat_nxt = 1'b1;
        if (SATURATE != 0) begin
          acc_nxt = sum_ext[OUT_WIDTH] ? SUM_MIN : SUM_MAX;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      acc       <= '0;
      sat_flag  <= 1'b0;
      syn_cnt   <= '0;
      nrn_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_idx   <= '0;
      out_sat   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ACC;
            busy     <= 1'b1;
            in_ready <= 1'b1;
            acc      <= '0;
            sat_flag <= 1'b0;
            syn_cnt  <= '0;
            nrn_cnt  <= '0;
          end
        end
        ACC: begin
          // in_ready is always high here, so in_valid alone marks a beat.
          if (in_valid) begin
            acc      <= acc_nxt;
            sat_flag <= sat_nxt;
            if (syn_cnt == SYN_LAST) begin
              syn_cnt   <= '0;
              out_sum   <= acc_nxt;
              out_sat   <= sat_nxt;
              out_idx   <= nrn_cnt;
              state     <= EMIT;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              syn_cnt <= syn_cnt + SYN_W'(1);
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (nrn_cnt == NRN_LAST) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              nrn_cnt  <= nrn_cnt + IDX_W'(1);
              acc      <= '0;
              sat_flag <= 1'b0;
              state    <= ACC;
              in_ready <= 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_synaptic_accumulator_seq.sv
// Bench for synaptic_accumulator_seq: a 16/24-bit instance plus 8/8-bit saturating and
// wrapping instances driven in lockstep from one vector table, checked via a scoreboard.
module tb_synaptic_accumulator_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, in_valid, in_spike, out_ready;
  logic [15:0] in_weight;

  logic        busy_m, done_m, in_ready_m, out_valid_m, out_sat_m;
  logic [23:0] out_sum_m;
  logic [0:0]  out_idx_m;
  logic        busy_s, done_s, in_ready_s, out_valid_s, out_sat_s;
  logic [7:0]  out_sum_s;
  logic [0:0]  out_idx_s;
  logic        busy_w, done_w, in_ready_w, out_valid_w, out_sat_w;
  logic [7:0]  out_sum_w;
  logic [0:0]  out_idx_w;

  synaptic_accumulator_seq #(.N_NEURON(2), .N_SYN(4), .WIDTH(16), .OUT_WIDTH(24), .SATURATE(1)) dut_m (
    .clk(clk), .reset(reset), .start(start), .busy(busy_m), .done(done_m),
    .in_valid(in_valid), .in_ready(in_ready_m), .in_weight(in_weight), .in_spike(in_spike),
    .out_valid(out_valid_m), .out_ready(out_ready), .out_sum(out_sum_m), .out_idx(out_idx_m),
    .out_sat(out_sat_m));

  synaptic_accumulator_seq #(.N_NEURON(2), .N_SYN(4), .WIDTH(8), .OUT_WIDTH(8), .SATURATE(1)) dut_s (
    .clk(clk), .reset(reset), .start(start), .busy(busy_s), .done(done_s),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_weight(in_weight[7:0]), .in_spike(in_spike),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_sum(out_sum_s), .out_idx(out_idx_s),
    .out_sat(out_sat_s));

  synaptic_accumulator_seq #(.N_NEURON(2), .N_SYN(4), .WIDTH(8), .OUT_WIDTH(8), .SATURATE(0)) dut_w (
    .clk(clk), .reset(reset), .start(start), .busy(busy_w), .done(done_w),
    .in_valid(in_valid), .in_ready(in_ready_w), .in_weight(in_weight[7:0]), .in_spike(in_spike),
    .out_valid(out_valid_w), .out_ready(out_ready), .out_sum(out_sum_w), .out_idx(out_idx_w),
    .out_sat(out_sat_w));

  typedef struct {
    logic [15:0] w [4];
    logic [3:0]  sp;
    int          em, es, ew;
    bit          sm, ss, sw;
  } vec_t;

  typedef struct {
    int idx;
    int em, es, ew;
    bit sm, ss, sw;
  } exp_t;

  vec_t tbl [8];
  exp_t sbq [$];

  int errors = 0;
  int checks = 0;
  bit hold = 1'b0, done_due = 1'b0, post_done = 1'b0, frame_done = 1'b0, late_start = 1'b0;

  task automatic set_vec(input int i, input int w0, input int w1, input int w2, input int w3,
                         input logic [3:0] sp, input int em, input bit sm, input int es,
                         input bit ss, input int ew, input bit sw);
    tbl[i].w[0] = 16'(w0);
    tbl[i].w[1] = 16'(w1);
    tbl[i].w[2] = 16'(w2);
    tbl[i].w[3] = 16'(w3);
    tbl[i].sp = sp;
    tbl[i].em = em; tbl[i].sm = sm;
    tbl[i].es = es; tbl[i].ss = ss;
    tbl[i].ew = ew; tbl[i].sw = sw;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting (t=%0t)", nm, $time);
  endtask

  // Runs at the falling edge; an output seen valid with out_ready high is taken at the next rise.
  task automatic monitor();
    exp_t e;
    if (post_done) begin
      check("done_one_cycle", int'(done_m), 0);
      post_done = 1'b0;
    end
    if (done_due) begin
      check("done_pulse", int'(done_m), 1);
      check("idle_after_done", int'(busy_m), 0);
      done_due   = 1'b0;
      post_done  = 1'b1;
      frame_done = 1'b1;
      if (late_start) start = 1'b0;
    end
    if (out_valid_m && out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: sum=%0d with nothing expected", $signed(out_sum_m));
      end else begin
        e = sbq.pop_front();
        check("sum_m", int'($signed(out_sum_m)), e.em);
        check("idx_m", int'(out_idx_m), e.idx);
        check("sat_m", int'(out_sat_m), int'(e.sm));
        check("valid_s8_w8", int'({out_valid_s, out_valid_w}), 3);
        check("sum_sat8", int'($signed(out_sum_s)), e.es);
        check("sat_sat8", int'(out_sat_s), int'(e.ss));
        check("sum_wrap8", int'($signed(out_sum_w)), e.ew);
        check("sat_wrap8", int'(out_sat_w), int'(e.sw));
        if (e.idx == 1) done_due = 1'b1;
      end
    end
  endtask

  task automatic tick(output bit rdy);
    @(negedge clk);
    monitor();
    rdy = in_ready_m;
    @(posedge clk);
    #1;
    out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_beat(input logic [15:0] w, input bit sp, input bit stall);
    bit rdy;
    if (stall) begin
      while ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        tick(rdy);
      end
    end
    in_valid  = 1'b1;
    in_weight = w;
    in_spike  = sp;
    for (int k = 0; k < 100; k++) begin
      tick(rdy);
      if (rdy) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    fail_timeout("beat_accept");
  endtask

  task automatic send_neuron(input int v, input int idx, input bit poke);
    exp_t e;
    e.idx = idx;
    e.em = tbl[v].em; e.sm = tbl[v].sm;
    e.es = tbl[v].es; e.ss = tbl[v].ss;
    e.ew = tbl[v].ew; e.sw = tbl[v].sw;
    sbq.push_back(e);
    for (int b = 0; b < 4; b++) begin
      if (poke && b == 2) start = 1'b1;
      send_beat(tbl[v].w[b], tbl[v].sp[b], 1'b1);
      if (!late_start) start = 1'b0;
    end
  endtask

  task automatic begin_frame();
    bit rdy;
    frame_done = 1'b0;
    start = 1'b1;
    tick(rdy);
    start = 1'b0;
    check("acc_entry_ready", int'(in_ready_m), 1);
    check("acc_entry_busy", int'(busy_m), 1);
  endtask

  task automatic wait_done();
    bit rdy;
    for (int k = 0; k < 200 && !frame_done; k++) tick(rdy);
    if (!frame_done) fail_timeout("frame_done");
    check("scoreboard_drained", sbq.size(), 0);
  endtask

  task automatic run_frame(input int va, input int vb, input bit poke);
    begin_frame();
    send_neuron(va, 0, poke);
    send_neuron(vb, 1, 1'b0);
    wait_done();
  endtask

  initial begin
    bit rdy;
    //      idx  w0    w1    w2    w3  spikes  main      sat8      wrap8
    set_vec(0,   1,    2,    3,    4, 4'b1111,   10, 0,   10, 0,   10, 0);
    set_vec(1,  -5,    0,    0,    0, 4'b1111,   -5, 0,   -5, 0,   -5, 0);
    set_vec(2, 100,  200,  300,  400, 4'b0101,  400, 0,  127, 1, -112, 1);
    set_vec(3, 100,  100,  -50,    0, 4'b1111,  150, 0,   77, 1, -106, 1);
    set_vec(4, 100,  100,    0,    0, 4'b1111,  200, 0,  127, 1,  -56, 1);
    set_vec(5, -100, -100, -100,  10, 4'b1111, -290, 0, -118, 1,  -34, 1);
    set_vec(6, 32767, -32768,  7,  -1, 4'b1111,    5, 0,    5, 0,    5, 0);
    set_vec(7,   5,    6,    7,    8, 4'b0000,    0, 0,    0, 0,    0, 0);

    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_spike = 1'b0;
    in_weight = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready_m), 0);
    check("rst_out_valid", int'(out_valid_m), 0);
    check("rst_busy", int'(busy_m), 0);
    check("rst_done", int'(done_m), 0);
    check("rst_out_sum", int'(out_sum_m), 0);
    check("rst_out_idx", int'(out_idx_m), 0);
    check("rst_out_sat", int'(out_sat_m), 0);
    check("rst_narrow", int'({busy_s, done_s, in_ready_s, out_idx_s, busy_w, done_w, in_ready_w, out_idx_w}), 0);
    reset = 1'b1;
    tick(rdy);

    for (int f = 0; f < 3; f++) run_frame(2 * f, 2 * f + 1, 1'b0);
    run_frame(6, 7, 1'b1);

    // Output backpressure: sum and index must hold while downstream stalls.
    hold = 1'b1;
    out_ready = 1'b0;
    begin_frame();
    send_neuron(4, 0, 1'b0);
    for (int k = 0; k < 20 && !out_valid_m; k++) tick(rdy);
    if (!out_valid_m) fail_timeout("bp_out_valid");
    for (int k = 0; k < 10; k++) begin
      tick(rdy);
      check("bp_sum", int'($signed(out_sum_m)), 200);
      check("bp_idx", int'(out_idx_m), 0);
      check("bp_in_ready", int'(in_ready_m), 0);
      check("bp_out_valid", int'(out_valid_m), 1);
    end
    hold = 1'b0;
    send_neuron(5, 1, 1'b0);
    wait_done();

    // Mid-frame reset after two beats, then a fresh frame must not see the partial sum.
    frame_done = 1'b0;
    start = 1'b1;
    tick(rdy);
    start = 1'b0;
    send_beat(tbl[0].w[0], 1'b1, 1'b0);
    send_beat(tbl[0].w[1], 1'b1, 1'b0);
    reset = 1'b0;
    #1;
    check("arst_in_ready", int'(in_ready_m), 0);
    check("arst_busy", int'(busy_m), 0);
    check("arst_out_valid", int'(out_valid_m), 0);
    check("arst_out_sum", int'(out_sum_m), 0);
    check("arst_out_idx", int'(out_idx_m), 0);
    check("arst_out_sat", int'(out_sat_m), 0);
    check("arst_done", int'(done_m), 0);
    repeat (2) tick(rdy);
    reset = 1'b1;
    tick(rdy);
    run_frame(0, 1, 1'b0);

    // start held through the final accept edge must not restart the block.
    late_start = 1'b1;
    begin_frame();
    send_neuron(3, 0, 1'b0);
    send_neuron(5, 1, 1'b0);
    start = 1'b1;
    wait_done();
    start = 1'b0;
    late_start = 1'b0;
    tick(rdy);
    check("start_at_done_busy", int'(busy_m), 0);
    check("start_at_done_in_ready", int'(in_ready_m), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
